decode_stage_r32: RTL and testbench
===================================

# decode_stage_r32

Registered, handshaked RV32I decode stage between fetch and execute, superseding the purely combinational decoder. It adds the following:
- valid/ready flow control;
- a one-entry output register;
- flush on taken branch;
- load-use hazard stalling;
- illegal-instruction detection;
- optional M-extension decode;
- a stall-cycle counter.

Output fields carry the same control meaning as the current decoder, so execute-side wiring is unchanged apart from the wider ALU code.

## Interface
Parameters:
- dataW, 32, datapath width of PC and immediate (instruction width fixed at 32)
- ENABLE_M, 0, 1 = decode OP funct7=0000001 as M-extension ops
- LOAD_USE_STALL, 1, 1 = enable load-use hazard stall; 0 = never stall on hazard

Ports:
- clk  in  1  clock; one clock domain; all state on rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  kill output register contents, refuse input this cycle
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts in_ins/in_pc this cycle
- in_ins  in  32  raw instruction
- in_pc  in  dataW  instruction address
- out_valid  out  1  output register holds a decoded instruction
- out_ready  in  1  execute consumes output this cycle
- out_pc  out  dataW  registered in_pc
- out_rs1, out_rs2, out_rd  out  5 each  ins[19:15], ins[24:20], ins[11:7]
- out_imm  out  dataW  sign-extended immediate of the decoded type (I/S/B/U/J)
- out_alu_code  out  5  {m_op, alt, funct3}; m_op=1 only for M ops
- out_use_imm, out_use_pc, out_reg_write, out_link_write  out  1 each  ALU-operand and writeback controls
- out_test_branch, out_always_branch, out_absolute_branch  out  1 each  PC controls
- out_branch_type  out  3  funct3
- out_ram_read, out_ram_write  out  1 each  LOAD only / STORE only
- out_illegal  out  1  instruction undefined; all other controls 0
- stall_count  out  32  saturating count of hazard-stall cycles

## Operation
Transfers:
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- in_ready = !flush && !hazard && (!out_valid || out_ready).

Hazard:
- Asserted when all of the following hold: LOAD_USE_STALL=1, out_valid, the output register holds a LOAD with out_rd≠0, in_valid, and the incoming instruction reads out_rd.
- rs1 is read by OP, OP-IMM, JALR, BRANCH, LOAD and STORE; rs2 is read by OP, BRANCH and STORE.

Output register update (priority order):
- flush → out_valid=0.
- Input transfer → load new decode, out_valid=1.
- Output transfer → out_valid=0 (bubble).
- Otherwise → hold.

Decode by opcode:
- OP-IMM 0010011: I-imm, use_imm, reg_write. alu = {0, ins[30] if funct3=5 else 0, funct3}.
- OP 0110011: reg_write, alu = {0, ins[30], funct3}. With ENABLE_M and funct7=0000001: alu = {1, 0, funct3}.
- LUI 0110111: U-imm, use_imm, reg_write, alu=CPY.
- AUIPC 0010111: U-imm, use_imm, use_pc, reg_write, alu=ADD.
- JAL 1101111: J-imm, use_imm, always_branch, link_write, reg_write, alu=CPY.
- JALR 1100111: as JAL, but with I-imm, absolute_branch and alu=ADD.
- BRANCH 1100011: B-imm, test_branch, use_pc, use_imm, alu=ADD.
- LOAD 0000011: I-imm, use_imm, reg_write, ram_read, alu=ADD.
- STORE 0100011: S-imm, use_imm, ram_write, alu=ADD.
- MISC-MEM 0001111: legal NOP, all controls 0.
- CPY/ADD values are taken from the shared ALU code include, zero-extended to 5 bits.

Illegal (out_illegal=1, controls 0, imm 0; fields, pc and handshake behave normally):
- Any other opcode, or ins[1:0]≠11.
- BRANCH funct3 ∈ {2,3}.
- LOAD funct3 ∈ {3,6,7}.
- STORE funct3 >2.
- JALR funct3≠0.
- OP funct7 ∉ {0000000, 0100000 with funct3 ∈ {0,5}, 0000001 when ENABLE_M}.
- OP-IMM funct3=1 with funct7≠0.
- OP-IMM funct3=5 with funct7 ∉ {0000000, 0100000}.

stall_count increments on each cycle where hazard=1 and flush=0; it saturates at 0xFFFFFFFF.

## Timing
- Decode latency 1 cycle: an input transfer at edge N makes fields visible after N.
- Full throughput of 1 instruction/cycle when out_ready=1 and no hazard.
- Load-use costs exactly one bubble: the load leaves, out_valid=0 for one cycle, then the consumer is accepted.
- Back-pressure: with out_valid=1 and out_ready=0, all outputs hold stable and in_ready=0.
- Flush during a simultaneous input/output handshake:
  - Output transfer still counts as consumed.
  - Input is not accepted.
  - out_valid=0 next cycle.
- Reset: out_valid=0, every out_* register 0, stall_count 0. in_ready reflects the combinational rule (1 when flush=0, since out_valid=0).
- Reset asserted mid-stall clears state immediately without waiting for clk.

## Test plan
- Reset, in_ins=0x00510093 (addi x1,x2,5), pc=0x100, out_ready=1 → next cycle out_valid=1, rs1=2, rd=1, imm=5, use_imm=1, reg_write=1, alu=0, pc=0x100.
- Back-to-back 0x0000A183 (lw x3,0(x1)) then 0x00118233 (add x4,x3,x1), out_ready=1 → in_ready=0 for 1 cycle, one out_valid=0 bubble, stall_count=1. Repeat with LOAD_USE_STALL=0 → no bubble.
- 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, test_branch=1, use_pc=1, branch_type=0. 0x022082B3 with ENABLE_M=1 → alu=5'b10000. With ENABLE_M=0 → out_illegal=1.
- Illegal set: 0x00000000, 0x0000B003 (LOAD funct3=3), 0x40001093 (slli, funct7=0x20) → out_illegal=1, all other controls 0.
- Hold out_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0. Assert flush with out_valid=1 → out_valid=0 next cycle, pending input not taken.
- Assert reset asynchronously between edges during a stall → out_valid and stall_count drop to 0 before the next clk edge.

Source files
------------

// File: rtl/decode_stage_r32.sv
// Registered RV32I decode stage with valid/ready handshake, taken-branch flush,
// load-use hazard stalling, illegal-instruction detection and optional M decode.
module decode_stage_r32 #(
  parameter int unsigned dataW          = 32,
  parameter bit          ENABLE_M       = 1'b0,
  parameter bit          LOAD_USE_STALL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic [dataW-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [dataW-1:0] out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [dataW-1:0] out_imm,
  output logic [4:0]       out_alu_code,
  output logic             out_use_imm,
  output logic             out_use_pc,
  output logic             out_reg_write,
  output logic             out_link_write,
  output logic             out_test_branch,
  output logic             out_always_branch,
  output logic             out_absolute_branch,
  output logic [2:0]       out_branch_type,
  output logic             out_ram_read,
  output logic             out_ram_write,
  output logic             out_illegal,
  output logic [31:0]      stall_count
);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // ALU codes shared with execute, zero-extended from the 4-bit {alt, funct3} space
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_CPY = 5'b01011;

  typedef struct packed {
    logic [dataW-1:0] pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [dataW-1:0] imm;
    logic [4:0]       aluCode;
    logic             useImm;
    logic             usePc;
    logic             regWrite;
    logic             linkWrite;
    logic             testBranch;
    logic             alwaysBranch;
    logic             absoluteBranch;
    logic [2:0]       branchType;
    logic             ramRead;
    logic             ramWrite;
    logic             illegal;
  } decode_t;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_immI;
  logic [31:0] w_immS;
  logic [31:0] w_immB;
  logic [31:0] w_immU;
  logic [31:0] w_immJ;
  logic [31:0] w_imm32;
  logic        w_illegal;
  decode_t     w_dec;

  logic        w_readsRs1;
  logic        w_readsRs2;
  logic        w_hazard;
  logic        w_inXfer;
  logic        w_outXfer;

  decode_t     r_dec;
  logic        r_outValid;
  logic [31:0] r_stallCount;

  assign w_opcode = in_ins[6:0];
  assign w_funct3 = in_ins[14:12];
  assign w_funct7 = in_ins[31:25];

  assign w_immI = {{20{in_ins[31]}}, in_ins[31:20]};
  assign w_immS = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
  assign w_immB = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
  assign w_immU = {in_ins[31:12], 12'b0};
  assign w_immJ = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};

  always_comb begin
    w_dec            = '0;
    w_imm32          = '0;
    w_illegal        = 1'b0;
    w_dec.branchType = w_funct3;
    if (in_ins[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (w_opcode)
        OPC_OPIMM: begin
          w_imm32        = w_immI;
          w_dec.useImm   = 1'b1;
          w_dec.regWrite = 1'b1;
          w_dec.aluCode  = {1'b0, (w_funct3 == 3'd5) & in_ins[30], w_funct3};
          if (w_funct3 == 3'd1 && w_funct7 != F7_BASE)
            w_illegal = 1'b1;
          if (w_funct3 == 3'd5 && w_funct7 != F7_BASE && w_funct7 != F7_ALT)
            w_illegal = 1'b1;
        end
        OPC_OP: begin
          w_dec.regWrite = 1'b1;
          if (w_funct7 == F7_BASE)
            w_dec.aluCode = {2'b00, w_funct3};
          else if (w_funct7 == F7_ALT && (w_funct3 == 3'd0 || w_funct3 == 3'd5))
            w_dec.aluCode = {2'b01, w_funct3};
          else if (ENABLE_M && w_funct7 == F7_MUL)
            w_dec.aluCode = {2'b10, w_funct3};
          else
            w_illegal = 1'b1;
        end
        OPC_LUI: begin
          w_imm32        = w_immU;
          w_dec.useImm   = 1'b1;
          w_dec.regWrite = 1'b1;
          w_dec.aluCode  = ALU_CPY;
        end
        OPC_AUIPC: begin
          w_imm32        = w_immU;
          w_dec.useImm   = 1'b1;
          w_dec.usePc    = 1'b1;
          w_dec.regWrite = 1'b1;
          w_dec.aluCode  = ALU_ADD;
        end
        OPC_JAL: begin
          w_imm32            = w_immJ;
          w_dec.useImm       = 1'b1;
          w_dec.alwaysBranch = 1'b1;
          w_dec.linkWrite    = 1'b1;
          w_dec.regWrite     = 1'b1;
          w_dec.aluCode      = ALU_CPY;
        end
        OPC_JALR: begin
          w_imm32              = w_immI;
          w_dec.useImm         = 1'b1;
          w_dec.alwaysBranch   = 1'b1;
          w_dec.absoluteBranch = 1'b1;
          w_dec.linkWrite      = 1'b1;
          w_dec.regWrite       = 1'b1;
          w_dec.aluCode        = ALU_ADD;
          if (w_funct3 != 3'd0)
            w_illegal = 1'b1;
        end
        OPC_BRANCH: begin
          w_imm32          = w_immB;
          w_dec.testBranch = 1'b1;
          w_dec.usePc      = 1'b1;
          w_dec.useImm     = 1'b1;
          w_dec.aluCode    = ALU_ADD;
          if (w_funct3 == 3'd2 || w_funct3 == 3'd3)
            w_illegal = 1'b1;
        end
        OPC_LOAD: begin
          w_imm32        = w_immI;
          w_dec.useImm   = 1'b1;
          w_dec.regWrite = 1'b1;
          w_dec.ramRead  = 1'b1;
          w_dec.aluCode  = ALU_ADD;
          if (w_funct3 == 3'd3 || w_funct3 == 3'd6 || w_funct3 == 3'd7)
            w_illegal = 1'b1;
        end
        OPC_STORE: begin
          w_imm32        = w_immS;
          w_dec.useImm   = 1'b1;
          w_dec.ramWrite = 1'b1;
          w_dec.aluCode  = ALU_ADD;
          if (w_funct3 > 3'd2)
            w_illegal = 1'b1;
        end
        OPC_MISC: begin
          w_dec.branchType = 3'd0;
        end
        default: begin
          w_illegal = 1'b1;
        end
      endcase
    end

    // An undefined instruction still carries its raw fields and pc through the pipe
    if (w_illegal) begin
      w_dec   = '0;
      w_imm32 = '0;
    end
    w_dec.pc      = in_pc;
    w_dec.rs1     = in_ins[19:15];
    w_dec.rs2     = in_ins[24:20];
    w_dec.rd      = in_ins[11:7];
    w_dec.illegal = w_illegal;
    w_dec.imm     = dataW'($signed(w_imm32));
  end

  assign w_readsRs1 = (w_opcode == OPC_OP)     || (w_opcode == OPC_OPIMM) ||
                      (w_opcode == OPC_JALR)   || (w_opcode == OPC_BRANCH) ||
                      (w_opcode == OPC_LOAD)   || (w_opcode == OPC_STORE);
  assign w_readsRs2 = (w_opcode == OPC_OP) || (w_opcode == OPC_BRANCH) ||
                      (w_opcode == OPC_STORE);

  assign w_hazard = LOAD_USE_STALL && r_outValid && r_dec.ramRead && (r_dec.rd != 5'd0) &&
                    in_valid &&
                    ((w_readsRs1 && in_ins[19:15] == r_dec.rd) ||
                     (w_readsRs2 && in_ins[24:20] == r_dec.rd));

  assign in_ready  = !flush && !w_hazard && (!r_outValid || out_ready);
  assign w_inXfer  = in_valid && in_ready;
  assign w_outXfer = r_outValid && out_ready;

  // Flush beats a new decode, which beats draining into a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dec      <= '0;
      r_outValid <= 1'b0;
    end else if (flush) begin
      r_outValid <= 1'b0;
    end else if (w_inXfer) begin
      r_dec      <= w_dec;
      r_outValid <= 1'b1;
    end else if (w_outXfer) begin
      r_outValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stallCount <= '0;
    else if (w_hazard && !flush && r_stallCount != 32'hFFFF_FFFF)
      r_stallCount <= r_stallCount + 32'd1;
  end

  assign out_valid           = r_outValid;
  assign out_pc              = r_dec.pc;
  assign out_rs1             = r_dec.rs1;
  assign out_rs2             = r_dec.rs2;
  assign out_rd              = r_dec.rd;
  assign out_imm             = r_dec.imm;
  assign out_alu_code        = r_dec.aluCode;
  assign out_use_imm         = r_dec.useImm;
  assign out_use_pc          = r_dec.usePc;
  assign out_reg_write       = r_dec.regWrite;
  assign out_link_write      = r_dec.linkWrite;
  assign out_test_branch     = r_dec.testBranch;
  assign out_always_branch   = r_dec.alwaysBranch;
  assign out_absolute_branch = r_dec.absoluteBranch;
  assign out_branch_type     = r_dec.branchType;
  assign out_ram_read        = r_dec.ramRead;
  assign out_ram_write       = r_dec.ramWrite;
  assign out_illegal         = r_dec.illegal;
  assign stall_count         = r_stallCount;

endmodule

// File: tb/tb_decode_stage_r32.sv
// Bench for decode_stage_r32: one instance with M decode and hazard stalling,
// a second with both disabled, sharing the same stimulus.
module tb_decode_stage_r32;

  localparam logic [4:0] ALU_CPY = 5'b01011;

  localparam logic [9:0] C_ILL  = 10'h200;
  localparam logic [9:0] C_IMM  = 10'h100;
  localparam logic [9:0] C_PC   = 10'h080;
  localparam logic [9:0] C_RW   = 10'h040;
  localparam logic [9:0] C_LINK = 10'h020;
  localparam logic [9:0] C_TB   = 10'h010;
  localparam logic [9:0] C_AB   = 10'h008;
  localparam logic [9:0] C_ABS  = 10'h004;
  localparam logic [9:0] C_RR   = 10'h002;
  localparam logic [9:0] C_WR   = 10'h001;

  localparam logic [31:0] INS_ADDI = 32'h00510093;
  localparam logic [31:0] INS_LW   = 32'h0000A183;
  localparam logic [31:0] INS_ADD  = 32'h00118233;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [9:0]  ctl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  bt;
    logic        ill2;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        inValid;
  logic        outReady;
  logic [31:0] inIns;
  logic [31:0] inPc;

  logic        inReady, outValid;
  logic [31:0] outPc, outImm, stallCount;
  logic [4:0]  outRs1, outRs2, outRd, outAlu;
  logic        outUseImm, outUsePc, outRegWrite, outLinkWrite;
  logic        outTestBranch, outAlwaysBranch, outAbsBranch;
  logic [2:0]  outBranchType;
  logic        outRamRead, outRamWrite, outIllegal;

  logic        d2InReady, d2OutValid;
  logic [31:0] d2Pc, d2Imm, d2StallCount;
  logic [4:0]  d2Rs1, d2Rs2, d2Rd, d2Alu;
  logic        d2UseImm, d2UsePc, d2RegWrite, d2LinkWrite;
  logic        d2TestBranch, d2AlwaysBranch, d2AbsBranch;
  logic [2:0]  d2BranchType;
  logic        d2RamRead, d2RamWrite, d2Illegal;

  logic [9:0]  dutCtl;
  assign dutCtl = {outIllegal, outUseImm, outUsePc, outRegWrite, outLinkWrite,
                   outTestBranch, outAlwaysBranch, outAbsBranch, outRamRead, outRamWrite};

  vec_t vecs[16];
  int   checkCount = 0;
  int   passCount  = 0;

  decode_stage_r32 #(.dataW(32), .ENABLE_M(1'b1), .LOAD_USE_STALL(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_ins(inIns), .in_pc(inPc),
    .out_valid(outValid), .out_ready(outReady), .out_pc(outPc),
    .out_rs1(outRs1), .out_rs2(outRs2), .out_rd(outRd), .out_imm(outImm),
    .out_alu_code(outAlu), .out_use_imm(outUseImm), .out_use_pc(outUsePc),
    .out_reg_write(outRegWrite), .out_link_write(outLinkWrite),
    .out_test_branch(outTestBranch), .out_always_branch(outAlwaysBranch),
    .out_absolute_branch(outAbsBranch), .out_branch_type(outBranchType),
    .out_ram_read(outRamRead), .out_ram_write(outRamWrite),
    .out_illegal(outIllegal), .stall_count(stallCount)
  );

  decode_stage_r32 #(.dataW(32), .ENABLE_M(1'b0), .LOAD_USE_STALL(1'b0)) dut2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid), .in_ready(d2InReady), .in_ins(inIns), .in_pc(inPc),
    .out_valid(d2OutValid), .out_ready(outReady), .out_pc(d2Pc),
    .out_rs1(d2Rs1), .out_rs2(d2Rs2), .out_rd(d2Rd), .out_imm(d2Imm),
    .out_alu_code(d2Alu), .out_use_imm(d2UseImm), .out_use_pc(d2UsePc),
    .out_reg_write(d2RegWrite), .out_link_write(d2LinkWrite),
    .out_test_branch(d2TestBranch), .out_always_branch(d2AlwaysBranch),
    .out_absolute_branch(d2AbsBranch), .out_branch_type(d2BranchType),
    .out_ram_read(d2RamRead), .out_ram_write(d2RamWrite),
    .out_illegal(d2Illegal), .stall_count(d2StallCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc,
                               input logic valid);
    inIns   = ins;
    inPc    = pc;
    inValid = valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    outReady = 1'b1;
    applyStimulus(32'h0, 32'h0, 1'b0);

    vecs[0]  = '{32'h00510093, 32'h00000005, 5'd0,      C_IMM | C_RW,                          5'd2,  5'd5,  5'd1,  3'd0, 1'b0};
    vecs[1]  = '{32'h0000A183, 32'h00000000, 5'd0,      C_IMM | C_RW | C_RR,                   5'd1,  5'd0,  5'd3,  3'd2, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 5'd0,      C_IMM | C_PC | C_TB,                   5'd0,  5'd0,  5'd29, 3'd0, 1'b0};
    vecs[3]  = '{32'h022082B3, 32'h00000000, 5'b10000,  C_RW,                                  5'd1,  5'd2,  5'd5,  3'd0, 1'b1};
    vecs[4]  = '{32'h00000000, 32'h00000000, 5'd0,      C_ILL,                                 5'd0,  5'd0,  5'd0,  3'd0, 1'b1};
    vecs[5]  = '{32'h0000B003, 32'h00000000, 5'd0,      C_ILL,                                 5'd1,  5'd0,  5'd0,  3'd0, 1'b1};
    vecs[6]  = '{32'h40001093, 32'h00000000, 5'd0,      C_ILL,                                 5'd0,  5'd0,  5'd1,  3'd0, 1'b1};
    vecs[7]  = '{32'h00118233, 32'h00000000, 5'd0,      C_RW,                                  5'd3,  5'd1,  5'd4,  3'd0, 1'b0};
    vecs[8]  = '{32'h40335293, 32'h00000403, 5'b01101,  C_IMM | C_RW,                          5'd6,  5'd3,  5'd5,  3'd5, 1'b0};
    vecs[9]  = '{32'h123453B7, 32'h12345000, ALU_CPY,   C_IMM | C_RW,                          5'd8,  5'd3,  5'd7,  3'd5, 1'b0};
    vecs[10] = '{32'h008000EF, 32'h00000008, ALU_CPY,   C_IMM | C_AB | C_LINK | C_RW,          5'd0,  5'd8,  5'd1,  3'd0, 1'b0};
    vecs[11] = '{32'h00008067, 32'h00000000, 5'd0,      C_IMM | C_AB | C_ABS | C_LINK | C_RW,  5'd1,  5'd0,  5'd0,  3'd0, 1'b0};
    vecs[12] = '{32'h0020A423, 32'h00000008, 5'd0,      C_IMM | C_WR,                          5'd1,  5'd2,  5'd8,  3'd2, 1'b0};
    vecs[13] = '{32'hFFFFF297, 32'hFFFFF000, 5'd0,      C_IMM | C_PC | C_RW,                   5'd31, 5'd31, 5'd5,  3'd7, 1'b0};
    vecs[14] = '{32'h0FF0000F, 32'h00000000, 5'd0,      10'h000,                               5'd0,  5'd31, 5'd0,  3'd0, 1'b0};
    vecs[15] = '{32'hFE002EE3, 32'h00000000, 5'd0,      C_ILL,                                 5'd0,  5'd0,  5'd29, 3'd0, 1'b1};

    #1;
    checkOutput("reset_valid_count", {outValid, stallCount}, 33'd0);
    checkOutput("reset_regs", {outPc, outImm, outAlu, dutCtl, outRd}, 84'd0);
    checkOutput("reset_in_ready", inReady, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Single-issue decode table, one idle cycle between entries
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].ins, 32'h100 + 32'(i * 4), 1'b1);
      step();
      checkOutput($sformatf("vec%0d", i),
                  {outValid, outPc, outImm, outAlu, dutCtl, outRs1, outRs2, outRd, outBranchType},
                  {1'b1, 32'h100 + 32'(i * 4), vecs[i].imm, vecs[i].alu, vecs[i].ctl,
                   vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].bt});
      checkOutput($sformatf("vec%0d_noM_illegal", i), d2Illegal, vecs[i].ill2);
      applyStimulus(32'h0, 32'h0, 1'b0);
      step();
    end

    // Load-use: one bubble with stalling, none without
    applyReset();
    outReady = 1'b1;
    applyStimulus(INS_LW, 32'h300, 1'b1);
    step();
    applyStimulus(INS_ADD, 32'h304, 1'b1);
    #1;
    checkOutput("lu_in_ready_stall", inReady, 1'b0);
    checkOutput("lu_in_ready_nostall", d2InReady, 1'b1);
    step();
    checkOutput("lu_bubble", outValid, 1'b0);
    checkOutput("lu_stall_count", stallCount, 32'd1);
    checkOutput("lu_nostall_consumer", {d2OutValid, d2Rd, d2Pc}, {1'b1, 5'd4, 32'h304});
    #1;
    checkOutput("lu_in_ready_after", inReady, 1'b1);
    step();
    checkOutput("lu_consumer", {outValid, outRd, outPc, stallCount}, {1'b1, 5'd4, 32'h304, 32'd1});
    checkOutput("lu_nostall_count", d2StallCount, 32'd0);
    applyStimulus(32'h0, 32'h0, 1'b0);
    step();

    // Back-pressure holds the output, then flush kills it and refuses the pending input
    applyReset();
    outReady = 1'b0;
    applyStimulus(INS_ADDI, 32'h200, 1'b1);
    step();
    applyStimulus(INS_ADD, 32'h204, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("bp_hold%0d", c), {inReady, outValid, outPc, outImm, outRd, dutCtl},
                  {1'b0, 1'b1, 32'h200, 32'h5, 5'd1, C_IMM | C_RW});
      step();
    end
    flush = 1'b1;
    #1;
    checkOutput("flush_in_ready", inReady, 1'b0);
    step();
    flush = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0);
    checkOutput("flush_kill", outValid, 1'b0);
    step();
    checkOutput("flush_no_take", outValid, 1'b0);

    // Flush while both handshakes would fire
    outReady = 1'b1;
    applyStimulus(INS_ADDI, 32'h240, 1'b1);
    step();
    checkOutput("flush_hs_setup", {outValid, outPc}, {1'b1, 32'h240});
    applyStimulus(INS_ADD, 32'h244, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0);
    checkOutput("flush_hs_valid", outValid, 1'b0);

    // Asynchronous reset in the middle of a persistent stall
    applyReset();
    outReady = 1'b0;
    applyStimulus(INS_LW, 32'h400, 1'b1);
    step();
    applyStimulus(INS_ADD, 32'h404, 1'b1);
    step();
    step();
    checkOutput("stall_two", {stallCount, inReady, outValid}, {32'd2, 1'b0, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", {outValid, stallCount, outRd, outPc}, 70'd0);
    checkOutput("async_reset_in_ready", inReady, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
